// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter with burst hold: a grant stays with one requester
// for up to weight[i] transfers (weight 0 counts as 1) before the pointer rotates.
module wrr_burst_arbiter #(
    parameter int N   = 4,
    parameter int WW  = 3,
    parameter int IDW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    last,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    gnt,
    output logic            gnt_vld,
    output logic [IDW-1:0]  gnt_id
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [WW-1:0]  credit;

    logic           cur_req;
    logic           cur_last;
    logic           transfer;
    logic           release_now;
    logic [IDW-1:0] nxt_ptr;
    logic [IDW-1:0] base;
    logic           win;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    logic [WW-1:0]  sel_weight;
    logic [WW-1:0]  load_credit;

    // On release the scan already starts past the current owner, so the owner
    // is considered last and only re-wins when nobody else is asking.
    always_comb begin
        cur_req     = req[gnt_id];
        cur_last    = last[gnt_id];
        transfer    = (state == GRANT) && cur_req && cur_last;
        release_now = (state == GRANT) && (!cur_req || (cur_last && (credit == WW'(1))));
        nxt_ptr     = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
        base        = release_now ? nxt_ptr : ptr;
        win         = 1'b0;
        sel         = '0;
        idx         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IDW'((int'(base) + k) % N);
            if (req[idx]) begin
                win = 1'b1;
                sel = idx;
            end
        end
        sel_weight  = weight[int'(sel)*WW +: WW];
        load_credit = (sel_weight == '0) ? WW'(1) : sel_weight;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            credit  <= '0;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            gnt_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win) begin
                        gnt     <= N'(1) << sel;
                        gnt_vld <= 1'b1;
                        gnt_id  <= sel;
                        credit  <= load_credit;
                        state   <= GRANT;
                    end else begin
                        gnt     <= '0;
                        gnt_vld <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr <= nxt_ptr;
                        if (win) begin
                            gnt     <= N'(1) << sel;
                            gnt_vld <= 1'b1;
                            gnt_id  <= sel;
                            credit  <= load_credit;
                        end else begin
                            gnt     <= '0;
                            gnt_vld <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (transfer) begin
                        credit <= credit - WW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= '0;
                    gnt_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Self-checking bench for wrr_burst_arbiter: a vector table drives one cycle per
// record, expected grants are queued on drive and compared after the next edge.
module tb_wrr_burst_arbiter;

    localparam int N   = 4;
    localparam int WW  = 3;
    localparam int IDW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    gnt;
    logic            gnt_vld;
    logic [IDW-1:0]  gnt_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            do_rst;
        logic [N-1:0]    req;
        logic [N-1:0]    last;
        logic [N*WW-1:0] weight;
        logic [N-1:0]    exp_gnt;
        logic            exp_vld;
        logic [IDW-1:0]  exp_id;
    } vec_t;

    typedef struct {
        int             tag;
        logic [N-1:0]   gnt;
        logic           vld;
        logic [IDW-1:0] id;
    } exp_t;

    vec_t vecs[64];
    int   num_vecs = 0;
    exp_t sb[$];

    wrr_burst_arbiter #(.N(N), .WW(WW), .IDW(IDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .last    (last),
        .weight  (weight),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [N*WW-1:0] w4(int a3, int a2, int a1, int a0);
        return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    task automatic addVec(input logic r, input logic [3:0] q, input logic [3:0] l,
                          input logic [11:0] w, input logic [3:0] g, input logic v,
                          input logic [1:0] id);
        vecs[num_vecs] = '{r, q, l, w, g, v, id};
        num_vecs++;
    endtask

    task automatic checkOutput(input string name, input int tag, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (step %0d): actual=%0h required=%0h", name, tag, act, exp);
        end
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic doReset();
        rst  = 1'b1;
        req  = '0;
        last = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int tag, input logic [3:0] q, input logic [3:0] l,
                                 input logic [11:0] w, input logic [3:0] g, input logic v,
                                 input logic [1:0] id);
        exp_t e;
        req    = q;
        last   = l;
        weight = w;
        e      = '{tag, g, v, id};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard underflow (step %0d)", tag);
        end else begin
            e = sb.pop_front();
            checkOutput("gnt", e.tag, 32'(gnt), 32'(e.gnt));
            checkOutput("gnt_vld", e.tag, 32'(gnt_vld), 32'(e.vld));
            checkOutput("gnt_id", e.tag, 32'(gnt_id), 32'(e.id));
        end
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        last   = '0;
        weight = '0;
        #2;
        checkOutput("reset gnt", 0, 32'(gnt), 0);
        checkOutput("reset gnt_vld", 0, 32'(gnt_vld), 0);
        checkOutput("reset gnt_id", 0, 32'(gnt_id), 0);
        @(negedge clk);
        rst = 1'b0;

        // Rotation at weight 1
        addVec(1, 4'hF, 4'hF, w4(1,1,1,1), 4'b0001, 1, 0);
        addVec(0, 4'hF, 4'hF, w4(1,1,1,1), 4'b0010, 1, 1);
        addVec(0, 4'hF, 4'hF, w4(1,1,1,1), 4'b0100, 1, 2);
        addVec(0, 4'hF, 4'hF, w4(1,1,1,1), 4'b1000, 1, 3);
        addVec(0, 4'hF, 4'hF, w4(1,1,1,1), 4'b0001, 1, 0);
        addVec(0, 4'h0, 4'h0, w4(1,1,1,1), 4'b0000, 0, 0);
        // Weighted burst: 3 on requester 0, 1 on requester 1
        addVec(1, 4'h3, 4'h3, w4(1,1,1,3), 4'b0001, 1, 0);
        addVec(0, 4'h3, 4'h3, w4(1,1,1,3), 4'b0001, 1, 0);
        addVec(0, 4'h3, 4'h3, w4(1,1,1,3), 4'b0001, 1, 0);
        addVec(0, 4'h3, 4'h3, w4(1,1,1,3), 4'b0010, 1, 1);
        addVec(0, 4'h3, 4'h3, w4(1,1,1,3), 4'b0001, 1, 0);
        addVec(0, 4'h0, 4'h0, w4(1,1,1,3), 4'b0000, 0, 0);
        // Early release of requester 2 with requester 3 pending (ptr=1 here)
        addVec(0, 4'h4, 4'h0, w4(1,5,1,1), 4'b0100, 1, 2);
        addVec(0, 4'h4, 4'h4, w4(1,5,1,1), 4'b0100, 1, 2);
        addVec(0, 4'h4, 4'h4, w4(1,5,1,1), 4'b0100, 1, 2);
        addVec(0, 4'h8, 4'h4, w4(1,5,1,1), 4'b1000, 1, 3);
        addVec(0, 4'h8, 4'h8, w4(1,5,1,1), 4'b1000, 1, 3);
        addVec(0, 4'h0, 4'h0, w4(1,5,1,1), 4'b0000, 0, 3);
        // Zero weight, sole requester; drop leaves ptr=2 in IDLE
        addVec(0, 4'h2, 4'h2, w4(1,1,0,1), 4'b0010, 1, 1);
        addVec(0, 4'h2, 4'h2, w4(1,1,0,1), 4'b0010, 1, 1);
        addVec(0, 4'h2, 4'h2, w4(1,1,0,1), 4'b0010, 1, 1);
        addVec(0, 4'h2, 4'h0, w4(1,1,0,1), 4'b0010, 1, 1);
        addVec(0, 4'h0, 4'h2, w4(1,1,0,1), 4'b0000, 0, 1);
        // IDLE with ptr=2: scan 2,3,0 picks 0; foreign last and mid-burst weight ignored
        addVec(0, 4'h3, 4'h0, w4(1,1,1,2), 4'b0001, 1, 0);
        addVec(0, 4'h3, 4'h2, w4(1,1,1,7), 4'b0001, 1, 0);
        addVec(0, 4'h3, 4'h1, w4(1,1,1,7), 4'b0001, 1, 0);
        addVec(0, 4'h3, 4'h1, w4(1,1,1,7), 4'b0010, 1, 1);
        addVec(0, 4'h3, 4'h3, w4(1,1,1,7), 4'b0001, 1, 0);
        addVec(0, 4'h0, 4'h0, w4(1,1,1,7), 4'b0000, 0, 0);

        for (int i = 0; i < num_vecs; i++) begin
            if (vecs[i].do_rst) doReset();
            applyStimulus(i + 1, vecs[i].req, vecs[i].last, vecs[i].weight,
                          vecs[i].exp_gnt, vecs[i].exp_vld, vecs[i].exp_id);
        end

        // Async reset in the middle of a 3-credit burst on requester 3
        doReset();
        applyStimulus(100, 4'h8, 4'h8, w4(3,1,1,1), 4'b1000, 1, 3);
        applyStimulus(101, 4'h8, 4'h8, w4(3,1,1,1), 4'b1000, 1, 3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst gnt", 102, 32'(gnt), 0);
        checkOutput("async rst gnt_vld", 102, 32'(gnt_vld), 0);
        checkOutput("async rst gnt_id", 102, 32'(gnt_id), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(103, 4'hF, 4'h0, w4(3,1,1,1), 4'b0001, 1, 0);
        applyStimulus(104, 4'hF, 4'hF, w4(3,1,1,1), 4'b0010, 1, 1);

        checkOutput("scoreboard drained", 105, 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
- Weighted round-robin arbiter that shares one downstream resource between N requesters.
- Grants are transaction-based: a grant is held across multiple transfers, up to a per-requester weight (credit), before rotating.
- Sits in front of shared bus/datapath ports where the existing 4-way round-robin arbiter lacks burst hold and weighting.
- Grant outputs are registered.

Parameters:
- N, 4, number of requesters (2..16)
- WW, 3, width of each per-requester weight field
- IDW, $clog2(N), width of gnt_id

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req  input  N  per-requester request level; bit i held high while requester i has work
- last  input  N  per-requester end-of-transfer strobe; only meaningful while that requester is granted
- weight  input  N*WW  quasi-static credits; field i is weight[i*WW +: WW]
- gnt  output  N  registered one-hot grant, or all-zero
- gnt_vld  output  1  registered; high exactly when gnt is non-zero
- gnt_id  output  IDW  registered; index of the granted requester, valid when gnt_vld is high

Behaviour:
- Reset values (async, applied immediately on rst high):
  - gnt=0, gnt_vld=0, gnt_id=0.
  - Pointer ptr=0, credit=0, state=IDLE.
- State IDLE:
  - Each cycle, if any req bit is set, select the first set bit scanning ptr, ptr+1, ... N-1, 0, ..., ptr-1 (circular).
  - The selection is registered: req seen in cycle t gives gnt in cycle t+1. Go to GRANT.
  - Load credit = weight[sel], with weight 0 treated as 1.
  - If no req is set, stay in IDLE with outputs 0.
- State GRANT (g = gnt_id):
  - Transfer: any cycle with req[g]=1 and last[g]=1.
  - On a transfer with credit>1: decrement credit, keep the grant.
  - On a transfer with credit==1, release.
  - If req[g]=0: release immediately. No transfer is counted, and last[g] is ignored.
  - last and req of non-granted requesters are ignored.
- Release (same cycle):
  - Set ptr = (g+1) mod N.
  - Re-arbitrate over the current-cycle req vector using the new ptr.
  - Requester g is included in that arbitration, so if it is the only requester it re-wins with a fresh credit.
  - If any requester wins: next cycle gnt moves directly to the winner, with no bubble. Stay in GRANT and reload credit from the winner's weight.
  - If none wins: next cycle gnt=0, gnt_vld=0, state IDLE.
- weight is sampled only when a grant is issued. Changes mid-burst do not affect the current credit.
- gnt is always one-hot or zero. gnt_vld == |gnt. gnt_id holds its last value while gnt_vld=0.
- Credit width is WW bits. The maximum burst is 2^WW - 1 transfers.
- Reset mid-burst: outputs clear asynchronously. After rst falls, arbitration restarts from ptr=0 and the interrupted burst is not resumed.
- Fairness: any requester holding req high is granted within (N-1) bursts of others, each at most 2^WW - 1 transfers.

Test Plan:
1. Rotation at weight 1:
   - Stimulus: reset, then all weights=1, req=4'b1111, last=4'b1111 every cycle.
   - Expected: gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with gnt_vld steady high and no bubbles.
2. Weighted burst:
   - Stimulus: weight0=3, weight1=1, req=4'b0011, last pulsed every cycle.
   - Expected: gnt=0001 for exactly 3 cycles, then 0010 for 1 cycle, then 0001 again.
   - Check that gnt_id tracks gnt (0, 1, 0).
3. Early release:
   - Stimulus: weight2=5, req=4'b0100 granted; drop req[2] after 2 transfers with req=4'b1000 pending.
   - Expected: the cycle after the drop, gnt=1000 and ptr=3.
4. Zero weight and sole requester:
   - Stimulus: weight1=0, only req[1] high, last every cycle.
   - Expected: gnt=0010 continuously; each last causes release then re-grant to 1.
   - Expected: deasserting req[1] gives gnt=0 and gnt_vld=0 next cycle, and the block returns to IDLE.
5. IDLE latency and pointer:
   - Stimulus: from IDLE with ptr=2, assert req=4'b0011 in cycle t.
   - Expected: gnt=0001 at cycle t+1, because the scan order 2, 3, 0 selects 0.
6. Async reset mid-burst:
   - Stimulus: assert rst during a 3-credit burst on requester 3; release rst, then req=4'b1111.
   - Expected: gnt=0 immediately on rst, without waiting for a clock edge.
   - Expected: after release, the first grant is 0001 (ptr back to 0).
